usb_dev_dpdm: RTL

Device-side DP/DM line interface: the far end of the host's DP/DM driver in the USB host testbench system. Receives host packets by detecting sync, capturing the bitstream and closing on SE0 EOP. Transmits device response packets by serializing a parallel buffer with generated sync, two-cycle SE0 EOP and idle. One bit per clk; no NRZI or bit-stuffing here, which belong to the encoding layers.

---
 rtl/usb_dev_pkg.sv | 56 +++++
 rtl/usb_dev_rx.sv | 88 ++++++++
 rtl/usb_dev_dpdm.sv | 121 ++++++++++++
 3 files changed

// File: rtl/usb_dev_pkg.sv
// Shared constants, line-state coding and FSM state types for the device DP/DM interface.
// Latency: none (definitions only).
// Backpressure: none.
package usb_dev_pkg;

  // Payload capacity in bits, not counting sync.
  localparam int MAX_BITS = 96;
  // SE0 cycles in a transmitted end-of-packet.
  localparam int EOP_SE0  = 2;
  // Sync symbols per packet.
  localparam int SYNC_LEN = 8;
  // Width of the payload length fields.
  localparam int LEN_W    = 7;

  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BITS);
  localparam logic [LEN_W-1:0] EOP_LAST = LEN_W'(EOP_SE0 - 1);

  // Sync pattern J K J K J K J J; bit i is the dp level of symbol i (J=0, K=1).
  localparam logic [SYNC_LEN-1:0] SYNC_DP = 8'b0010_1010;

  typedef enum logic [1:0] {J, K, SE0, SE1} line_state_t;

  typedef enum logic [1:0] {RX_SEEK, RX_DATA, RX_WAIT_IDLE} rx_state_t;

  typedef enum logic [2:0] {TX_IDLE, TX_SYNC, TX_DATA, TX_EOP, TX_LAST} tx_state_t;

  // Classify a sampled (dp, dm) pair.
  function automatic line_state_t line_decode(input logic dp, input logic dm);
    line_state_t ls;
    case ({dp, dm})
      2'b01:   ls = J;
      2'b10:   ls = K;
      2'b00:   ls = SE0;
      default: ls = SE1;
    endcase
    return ls;
  endfunction

  // Levels {dp, dm} that put a given line state on the bus.
  function automatic logic [1:0] line_encode(input line_state_t ls);
    logic [1:0] lv;
    case (ls)
      J:       lv = 2'b01;
      K:       lv = 2'b10;
      SE0:     lv = 2'b00;
      default: lv = 2'b11;
    endcase
    return lv;
  endfunction

  // Expected line state of sync symbol idx.
  function automatic line_state_t sync_sym(input logic [2:0] idx);
    return SYNC_DP[idx] ? K : J;
  endfunction

endpackage

// File: rtl/usb_dev_rx.sv
// Receive side: hunts for sync, captures payload bits one per clk, closes on SE0 EOP.
// Latency: rx_active one edge after the 8th sync symbol is sampled; rx_valid one edge after the first SE0.
// Backpressure: none; held in SEEK and inputs ignored while rx_hold (transmit) is high.
module usb_dev_rx
  import usb_dev_pkg::*;
(
  input  logic                clk,
  input  logic                rst_b,
  input  logic                dp_in,
  input  logic                dm_in,
  input  logic                rx_hold,
  output logic [MAX_BITS-1:0] rx_data,
  output logic [LEN_W-1:0]    rx_len,
  output logic                rx_valid,
  output logic                rx_ovf,
  output logic                rx_active
);

  rx_state_t   state;
  logic [2:0]  sync_cnt;
  line_state_t ls;

  assign ls = line_decode(dp_in, dm_in);

  // Sync hunt, payload capture and EOP detection.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= RX_SEEK;
      sync_cnt  <= '0;
      rx_data   <= '0;
      rx_len    <= '0;
      rx_valid  <= 1'b0;
      rx_ovf    <= 1'b0;
      rx_active <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (rx_hold) begin
        // Our own transmission is on the bus: do not try to receive it.
        state     <= RX_SEEK;
        sync_cnt  <= '0;
        rx_active <= 1'b0;
      end else begin
        case (state)
          RX_SEEK: begin
            if (ls == sync_sym(sync_cnt)) begin
              if (sync_cnt == 3'(SYNC_LEN - 1)) begin
                // Full sync seen: previous packet's results are discarded here.
                state     <= RX_DATA;
                sync_cnt  <= '0;
                rx_active <= 1'b1;
                rx_data   <= '0;
                rx_len    <= '0;
                rx_ovf    <= 1'b0;
              end else begin
                sync_cnt <= sync_cnt + 3'd1;
              end
            end else begin
              // Restart the hunt; the offending sample may itself open a new sync.
              sync_cnt <= (ls == sync_sym(3'd0)) ? 3'd1 : 3'd0;
            end
          end

          RX_DATA: begin
            if (ls == SE0) begin
              state     <= RX_WAIT_IDLE;
              rx_valid  <= 1'b1;
              rx_active <= 1'b0;
            end else if (rx_len == MAX_LEN) begin
              // Buffer full: keep counting nothing, just remember we lost bits.
              rx_ovf <= 1'b1;
            end else begin
              rx_data[rx_len] <= dp_in;
              rx_len          <= rx_len + 7'd1;
            end
          end

          RX_WAIT_IDLE: begin
            // Rest of the EOP; SE1 glitches do not count as idle.
            if (ls == K) state <= RX_SEEK;
          end

          default: state <= RX_SEEK;
        endcase
      end
    end
  end

endmodule

// File: rtl/usb_dev_dpdm.sv
// Device-side DP/DM line interface: receive via usb_dev_rx, transmit sync + payload + SE0 EOP + idle.
// Latency: tx_start sampled at edge N puts sync symbol 0 on the bus from edge N+1; busy for 8+len+EOP_SE0+1 cycles.
// Backpressure: tx_start dropped while tx_busy or rx_active; no receive backpressure.
module usb_dev_dpdm
  import usb_dev_pkg::*;
(
  input  logic                clk,
  input  logic                rst_b,
  input  logic                dp_in,
  input  logic                dm_in,
  output logic                dp_out,
  output logic                dm_out,
  output logic                oe,
  output logic [MAX_BITS-1:0] rx_data,
  output logic [LEN_W-1:0]    rx_len,
  output logic                rx_valid,
  output logic                rx_ovf,
  output logic                rx_active,
  input  logic                tx_start,
  input  logic [MAX_BITS-1:0] tx_data,
  input  logic [LEN_W-1:0]    tx_len,
  output logic                tx_busy,
  output logic                tx_done
);

  tx_state_t           tx_state;
  logic [LEN_W-1:0]    tx_cnt;
  logic [LEN_W-1:0]    tx_len_q;
  logic [MAX_BITS-1:0] tx_buf;
  logic [LEN_W-1:0]    tx_len_clamped;
  logic                tx_accept;

  assign tx_len_clamped = (tx_len > MAX_LEN) ? MAX_LEN : tx_len;
  // A request is taken only from a quiet device: not mid-receive, not still finishing a send.
  assign tx_accept      = tx_start && !rx_active && !tx_busy;

  usb_dev_rx u_rx (
    .clk       (clk),
    .rst_b     (rst_b),
    .dp_in     (dp_in),
    .dm_in     (dm_in),
    .rx_hold   (tx_busy),
    .rx_data   (rx_data),
    .rx_len    (rx_len),
    .rx_valid  (rx_valid),
    .rx_ovf    (rx_ovf),
    .rx_active (rx_active)
  );

  // Transmit FSM; the line outputs register the symbol chosen by the current state,
  // so the bus lags the state by one cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_len_q <= '0;
      tx_buf   <= '0;
      dp_out   <= 1'b1;
      dm_out   <= 1'b0;
      oe       <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      // Output stage: drive what the present state asks for.
      tx_busy <= (tx_state != TX_IDLE);
      oe      <= (tx_state != TX_IDLE);
      tx_done <= (tx_state == TX_LAST);
      case (tx_state)
        TX_SYNC: {dp_out, dm_out} <= line_encode(sync_sym(tx_cnt[2:0]));
        TX_DATA: {dp_out, dm_out} <= {tx_buf[tx_cnt], ~tx_buf[tx_cnt]};
        TX_EOP:  {dp_out, dm_out} <= line_encode(SE0);
        default: {dp_out, dm_out} <= line_encode(K);
      endcase

      // State progression.
      case (tx_state)
        TX_IDLE: begin
          if (tx_accept) begin
            tx_state <= TX_SYNC;
            tx_cnt   <= '0;
            tx_buf   <= tx_data;
            tx_len_q <= tx_len_clamped;
          end
        end

        TX_SYNC: begin
          if (tx_cnt == LEN_W'(SYNC_LEN - 1)) begin
            tx_cnt   <= '0;
            // Empty payload skips straight to the EOP.
            tx_state <= (tx_len_q == '0) ? TX_EOP : TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 7'd1;
          end
        end

        TX_DATA: begin
          if (tx_cnt == tx_len_q - 7'd1) begin
            tx_cnt   <= '0;
            tx_state <= TX_EOP;
          end else begin
            tx_cnt <= tx_cnt + 7'd1;
          end
        end

        TX_EOP: begin
          if (tx_cnt == EOP_LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_LAST;
          end else begin
            tx_cnt <= tx_cnt + 7'd1;
          end
        end

        TX_LAST: tx_state <= TX_IDLE;

        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule
